int_controller: RTL and testbench
=================================

# int_controller

Eight-input interrupt controller between the peripheral interrupt lines (switchbank, timers, …) and the `mammal` CPU's `INT`/`intack` pins, replacing the fixed combinational priority encoder in the top level. It latches rising edges on `irq[7:0]` into a pending register, applies a software mask, tracks in-service levels for nested priority, and supplies a stable vector on the CPU data-in mux during `intack`. Software sees it as two words on the memory-mapped I/O bus: mask, and status/EOI.

## Interface
- `VECTOR_BASE`, 16'h0000, added to the winning IRQ index to form `vector`.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `irq`  in  8  device request lines, level; bit 0 highest priority.
- `intack`  in  1  CPU interrupt acknowledge; high for one or more cycles.
- `INT`  out  1  interrupt request to CPU.
- `vector`  out  16  vector for CPU `data_in` while `intack`=1.
- `cs`  in  1  register select from top-level address decode.
- `we`  in  1  write strobe (CPU `memwt`), qualified by `cs`.
- `a0`  in  1  register address: 0 = mask, 1 = status/EOI.
- `din`  in  16  write data.
- `dout`  out  16  read data; valid combinationally while `cs`=1.

## Operation
- State: `irq_q[7:0]` (previous `irq`), `IRR[7:0]` pending, `IMR[7:0]` mask, `ISR[7:0]` in-service, `ack_q` (previous `intack`), `vec_hold[15:0]`.
- Reset values: all registers 0; `INT`=0; `vector`=`VECTOR_BASE`+7; `dout`=0.
- Edge detect: `rise = irq & ~irq_q`; a `rise` bit sets its `IRR` bit at the next edge. A level held high across reset counts as a new edge after reset.
- Eligibility: bit i eligible iff `IRR[i]` & ~`IMR[i]` and no `ISR[j]` set for j ≤ i. `INT` = OR of eligible (combinational from registers).
- Selection: `sel` = lowest eligible index; if none, spurious: `sel`=7.
- Acknowledge start (`intack`=1, `ack_q`=0): at that edge, clear `IRR[sel]` and set `ISR[sel]` (no state change if spurious); load `vec_hold` = `VECTOR_BASE`+`sel`.
- `vector` = `ack_q` ? `vec_hold` : `VECTOR_BASE`+`sel`. Stable for the full `intack` pulse.
- Writes (`cs`&`we`): `a0`=0 → `IMR`←`din[7:0]`. `a0`=1 → non-specific EOI: clear lowest-index set bit of `ISR`; no effect if `ISR`=0; `din` ignored.
- Reads: `a0`=0 → {8'h00, `IMR`}; `a0`=1 → {`ISR`, `IRR`}. `dout`=0 when `cs`=0.
- Masked requests remain pending in `IRR`; unmasking raises `INT` with no further edge.

## Timing
- `irq` rise sampled at edge n → `IRR` set at edge n → `INT` high during cycle n+1 (one-cycle latency).
- `INT` drops the cycle after acknowledge start unless another eligible request remains.
- Same-edge conflicts: `rise` on bit i and acknowledge clear of `IRR[i]` → set wins (bit remains pending). EOI and acknowledge start same edge → EOI clears lowest bit of `ISR` as registered before the edge, then the acknowledged bit is set. Mask write and acknowledge start same edge → `sel` uses pre-write `IMR`.
- `intack` held multiple cycles: only the first cycle acts; re-arms after `intack` returns 0.
- `reset` asserted mid-acknowledge: all state cleared immediately; `vector` returns to `VECTOR_BASE`+7.

## Test plan
- Reset, pulse `irq[2]` high at edge 5 → `INT`=1 from cycle 6; `intack` 1 cycle → `vector`=16'h0002, status read {`ISR`,`IRR`}=16'h0400, `INT`=0.
- `irq[5]` and `irq[1]` rise same cycle → first ack vector 1, `INT` stays 0 (5 blocked? no: 5 > 1 in service) until EOI; after EOI `INT`=1, second ack vector 5.
- Nesting: ack IRQ4, then `irq[0]` rises → `INT`=1, ack vector 0, `ISR`=8'h11; EOI → `ISR`=8'h10; EOI → 8'h00.
- `IMR`=8'h04, `irq[2]` rises → `INT`=0, status `IRR`=8'h04; write `IMR`=0 → `INT`=1 next cycle.
- `intack` with nothing eligible → `vector`=`VECTOR_BASE`+7, `IRR`/`ISR` unchanged; `VECTOR_BASE`=16'h0010 build gives 16'h0017.
- `irq[3]` held high, `reset` pulsed during 3-cycle `intack` → all registers 0, then `IRR[3]`=1 one edge after reset release.

Source files
------------

// File: rtl/int_controller_if.sv
// Bus bundle between the interrupt controller, the CPU interrupt pins,
// the peripheral request lines and the memory-mapped register port.
interface int_controller_if;
    logic [7:0]  irq;
    logic        intack;
    logic        INT;
    logic [15:0] vector;
    logic        cs;
    logic        we;
    logic        a0;
    logic [15:0] din;
    logic [15:0] dout;

    modport master (
        output irq, intack, cs, we, a0, din,
        input  INT, vector, dout
    );

    modport slave (
        input  irq, intack, cs, we, a0, din,
        output INT, vector, dout
    );
endinterface

// File: rtl/int_controller.sv
// Eight-input edge-triggered interrupt controller with mask, nested
// in-service tracking, non-specific EOI and a stable acknowledge vector.
module int_controller #(
    parameter logic [15:0] VECTOR_BASE = 16'h0000
) (
    input  logic            clk,
    input  logic            reset,
    int_controller_if.slave bus
);

    logic [7:0]  irq_q_r;
    logic [7:0]  irr_r;
    logic [7:0]  imr_r;
    logic [7:0]  isr_r;
    logic        ack_q_r;
    logic [15:0] vec_hold_r;

    logic [7:0]  rise_s;
    logic [7:0]  eligible_s;
    logic        isr_seen_s;
    logic [2:0]  sel_s;
    logic        spurious_s;
    logic        ack_start_s;
    logic [7:0]  ack_mask_s;
    logic        mask_wr_s;
    logic        eoi_s;
    logic [7:0]  eoi_mask_s;
    logic [15:0] sel_vector_s;

    // Eligibility: a set in-service bit blocks its own level and every lower priority
    always_comb begin
        eligible_s = 8'h00;
        isr_seen_s = 1'b0;
        for (int i = 0; i < 8; i++) begin
            isr_seen_s    = isr_seen_s | isr_r[i];
            eligible_s[i] = irr_r[i] & ~imr_r[i] & ~isr_seen_s;
        end
    end

    // Priority select: lowest eligible index wins, 7 when nothing is eligible
    always_comb begin
        sel_s = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            sel_s = eligible_s[i] ? 3'(i) : sel_s;
        end
    end

    assign rise_s       = bus.irq & ~irq_q_r;
    assign spurious_s   = ~(|eligible_s);
    assign ack_start_s  = bus.intack & ~ack_q_r;
    assign ack_mask_s   = (ack_start_s && !spurious_s) ? (8'd1 << sel_s) : 8'd0;
    assign mask_wr_s    = bus.cs & bus.we & ~bus.a0;
    assign eoi_s        = bus.cs & bus.we & bus.a0;
    // Two's-complement trick isolates the lowest set in-service bit
    assign eoi_mask_s   = eoi_s ? (isr_r & (~isr_r + 8'd1)) : 8'd0;
    assign sel_vector_s = VECTOR_BASE + {13'd0, sel_s};

    // Controller state: edge history, pending, mask, in-service, acknowledge tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q_r    <= 8'h00;
            irr_r      <= 8'h00;
            imr_r      <= 8'h00;
            isr_r      <= 8'h00;
            ack_q_r    <= 1'b0;
            vec_hold_r <= 16'h0000;
        end else begin
            irq_q_r <= bus.irq;
            // A new rise on the bit being acknowledged keeps it pending
            irr_r   <= (irr_r & ~ack_mask_s) | rise_s;
            imr_r   <= mask_wr_s ? bus.din[7:0] : imr_r;
            isr_r   <= (isr_r & ~eoi_mask_s) | ack_mask_s;
            ack_q_r <= bus.intack;
            if (ack_start_s) begin
                vec_hold_r <= sel_vector_s;
            end else begin
                vec_hold_r <= vec_hold_r;
            end
        end
    end

    // Read mux: mask word or {in-service, pending} status word
    always_comb begin
        if (!bus.cs) begin
            bus.dout = 16'h0000;
        end else if (bus.a0) begin
            bus.dout = {isr_r, irr_r};
        end else begin
            bus.dout = {8'h00, imr_r};
        end
    end

    assign bus.INT    = |eligible_s;
    assign bus.vector = ack_q_r ? vec_hold_r : sel_vector_s;

endmodule

// File: tb/tb_int_controller.sv
// Randomized bench for int_controller: a behavioural model predicts INT,
// vector and dout every cycle; directed steps pin a few literal values.
module tb_int_controller;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    int_controller_if bus ();
    int_controller_if bus2 ();

    int_controller #(.VECTOR_BASE(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int_controller #(.VECTOR_BASE(16'h0010)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input bit [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 8;
    endfunction

    // ---------------- behavioural model ----------------
    bit [7:0]  m_pirq, m_irr, m_imr, m_isr;
    bit        m_ackp;
    bit [15:0] m_vhold;

    function automatic int winner();
        int top;
        bit [7:0] el;
        top = lowest(m_isr);
        el  = 8'h00;
        for (int i = 0; i < top; i++) el[i] = m_irr[i] & ~m_imr[i];
        return lowest(el);
    endfunction

    task automatic model_clear();
        m_pirq = 8'h00; m_irr = 8'h00; m_imr = 8'h00; m_isr = 8'h00;
        m_ackp = 1'b0;  m_vhold = 16'h0000;
    endtask

    // Compare process: check outputs mid-cycle, then advance the model at the edge
    initial begin
        model_clear();
        forever begin
            int w;
            bit [15:0] exp_vec, exp_dout;
            @(negedge clk);
            #2;
            if (reset) model_clear();
            w = winner();
            exp_vec = m_ackp ? m_vhold : 16'(w == 8 ? 7 : w);
            if (!bus.cs)     exp_dout = 16'h0000;
            else if (bus.a0) exp_dout = {m_isr, m_irr};
            else             exp_dout = {8'h00, m_imr};
            chk("model_INT", {15'd0, bus.INT}, {15'd0, w != 8});
            chk("model_vector", bus.vector, exp_vec);
            chk("model_dout", bus.dout, exp_dout);
            @(posedge clk);
            if (reset) begin
                model_clear();
            end else begin
                bit [7:0] rise, old_isr;
                rise    = bus.irq & ~m_pirq;
                old_isr = m_isr;
                w       = winner();
                if (bus.cs && bus.we && bus.a0 && lowest(old_isr) < 8)
                    m_isr[lowest(old_isr)] = 1'b0;
                if (bus.intack && !m_ackp) begin
                    m_vhold = 16'(w == 8 ? 7 : w);
                    if (w != 8) begin
                        m_irr[w] = 1'b0;
                        m_isr[w] = 1'b1;
                    end
                end
                m_irr = m_irr | rise;
                if (bus.cs && bus.we && !bus.a0) m_imr = bus.din[7:0];
                m_pirq = bus.irq;
                m_ackp = bus.intack;
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    // Driver: directed literal checks, then randomized traffic
    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1'b1;
        bus.irq = 8'h00; bus.intack = 1'b0; bus.cs = 1'b0; bus.we = 1'b0;
        bus.a0 = 1'b0; bus.din = 16'h0000;
        bus2.irq = 8'h00; bus2.intack = 1'b0; bus2.cs = 1'b0; bus2.we = 1'b0;
        bus2.a0 = 1'b0; bus2.din = 16'h0000;
        cyc(); cyc();
        reset = 1'b0;
        cyc(); #3;
        chk("reset_vector", bus.vector, 16'h0007);
        chk("reset_INT", {15'd0, bus.INT}, 16'h0000);
        chk("reset_dout", bus.dout, 16'h0000);
        chk("base10_reset_vector", bus2.vector, 16'h0017);

        // single request, acknowledge, status
        bus.irq = 8'h04;
        cyc(); #3;
        chk("irq2_INT", {15'd0, bus.INT}, 16'h0001);
        bus.intack = 1'b1; #1;
        chk("irq2_vector", bus.vector, 16'h0002);
        cyc();
        bus.intack = 1'b0; bus.irq = 8'h00; bus.cs = 1'b1; bus.a0 = 1'b1; #3;
        chk("irq2_status", bus.dout, 16'h0400);
        chk("irq2_INT_drop", {15'd0, bus.INT}, 16'h0000);
        bus.we = 1'b1;
        cyc();
        bus.we = 1'b0; #3;
        chk("eoi_status", bus.dout, 16'h0000);

        // masked request stays pending, unmask raises INT
        bus.a0 = 1'b0; bus.we = 1'b1; bus.din = 16'h0004;
        cyc();
        bus.we = 1'b0; bus.a0 = 1'b1; bus.irq = 8'h04;
        cyc(); #3;
        chk("masked_INT", {15'd0, bus.INT}, 16'h0000);
        chk("masked_status", bus.dout, 16'h0004);
        bus.a0 = 1'b0; bus.we = 1'b1; bus.din = 16'h0000;
        cyc();
        bus.we = 1'b0; #3;
        chk("unmask_INT", {15'd0, bus.INT}, 16'h0001);
        bus.intack = 1'b1;
        cyc();
        bus.intack = 1'b0; bus.a0 = 1'b1; bus.we = 1'b1;
        cyc();
        bus.we = 1'b0; bus.cs = 1'b0; bus.irq = 8'h00;

        // spurious acknowledge on the offset-base instance
        bus2.intack = 1'b1; #3;
        chk("base10_spurious_vector", bus2.vector, 16'h0017);
        cyc(); #3;
        chk("base10_held_vector", bus2.vector, 16'h0017);
        bus2.intack = 1'b0;

        // reset in the middle of a held acknowledge, level survives as an edge
        bus.irq = 8'h08;
        cyc();
        bus.intack = 1'b1;
        cyc();
        reset = 1'b1; bus.cs = 1'b1; bus.a0 = 1'b1; #3;
        chk("midack_reset_vector", bus.vector, 16'h0007);
        chk("midack_reset_status", bus.dout, 16'h0000);
        cyc();
        reset = 1'b0; bus.intack = 1'b0; #3;
        chk("post_reset_status", bus.dout, 16'h0000);
        cyc(); #3;
        chk("post_reset_irr3", bus.dout, 16'h0008);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            cyc();
            reset      = ($urandom_range(0, 299) == 0);
            bus.irq    = bus.irq ^ (($urandom_range(0, 3) == 0) ? 8'($urandom) & 8'($urandom) : 8'h00);
            bus.intack = ($urandom_range(0, 3) == 0) ? ~bus.intack : bus.intack;
            bus.cs     = ($urandom_range(0, 1) == 1);
            bus.we     = ($urandom_range(0, 4) == 0);
            bus.a0     = ($urandom_range(0, 3) != 0);
            bus.din    = 16'($urandom) & (($urandom_range(0, 1) == 1) ? 16'h00FF : 16'h00F0);
        end
        reset = 1'b0;
        cyc(); cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
